seq_det_arbiter: RTL and testbench

Shared serial-pattern detection controller. Two requesters each present a 1-bit serial stream; the block grants the single detection engine to one requester at a time for a frame of FRAME_LEN bits, using round-robin arbitration. While a requester holds the grant, the block searches its stream for a programmable 4-bit pattern (overlap allowed) and counts matches per requester. It sits between the serial front-ends and status/interrupt logic, and generalises the team's fixed 1001 Moore detector into a shared, configurable resource.

---
 rtl/seq_det_arbiter.sv | 127 ++++++++++++
 tb/tb_seq_det_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_arbiter.sv
// Shared 4-bit serial pattern detector with round-robin grant between two
// requesters. One frame of FRAME_LEN bits is searched per grant, overlap allowed.
module seq_det_arbiter #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       din,
  input  logic [3:0]       pat,
  input  logic             pat_load,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             match,
  output logic             match_id,
  output logic [CNT_W-1:0] match_cnt0,
  output logic [CNT_W-1:0] match_cnt1,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_t     state, state_nxt;
  logic       w;
  logic       last;
  logic [7:0] bitcnt;
  logic [2:0] hist;
  logic [3:0] patreg;

  logic       win;
  logic       bit_in;
  logic       abort;
  logic       last_bit;
  logic       hit;
  logic [3:0] cand;

  // Arbitration, candidate formation and match/abort/frame-end decode
  always_comb begin
    win = 1'b0;
    unique case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
    bit_in   = din[w];
    abort    = ~req[w];
    cand     = {hist, bit_in};
    last_bit = (bitcnt == LAST_IDX);
    hit      = (state == RUN) && !abort && (cand == patreg) && (bitcnt >= 8'd3);
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (|req) state_nxt = RUN;
      RUN: begin
        gnt  = w ? 2'b10 : 2'b01;
        busy = 1'b1;
        if (abort || last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Datapath: grant pointer, pattern register, history, bit counter, counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w          <= 1'b0;
      last       <= 1'b1;
      bitcnt     <= '0;
      hist       <= '0;
      patreg     <= 4'b1001;
      match      <= 1'b0;
      match_id   <= 1'b0;
      match_cnt0 <= '0;
      match_cnt1 <= '0;
    end else begin
      match <= hit;
      if (hit) begin
        match_id <= w;
        if (!w && (match_cnt0 != '1)) match_cnt0 <= match_cnt0 + CNT_W'(1);
        if (w && (match_cnt1 != '1))  match_cnt1 <= match_cnt1 + CNT_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (pat_load) patreg <= pat;
          if (|req) begin
            w      <= win;
            last   <= win;
            bitcnt <= '0;
            hist   <= '0;
          end
        end
        RUN: begin
          if (!abort) begin
            hist   <= {hist[1:0], bit_in};
            bitcnt <= bitcnt + 8'd1;
          end
        end
        DONE: begin
          hist   <= '0;
          bitcnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Scoreboard bench for seq_det_arbiter: a behavioural model predicts each
// cycle's outputs; a second instance with 2-bit counters covers saturation.
module tb_seq_det_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, din;
  logic [3:0] pat;
  logic       pat_load;

  logic [1:0] gnt, s_gnt;
  logic       busy, match, match_id, done;
  logic       s_busy, s_match, s_mid, s_done;
  logic [7:0] c0, c1;
  logic [1:0] s_c0, s_c1;

  always #5 clk = ~clk;

  seq_det_arbiter #(.FRAME_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .pat(pat), .pat_load(pat_load),
    .gnt(gnt), .busy(busy), .match(match), .match_id(match_id),
    .match_cnt0(c0), .match_cnt1(c1), .done(done)
  );

  seq_det_arbiter #(.FRAME_LEN(8), .CNT_W(2)) sat (
    .clk(clk), .rst(rst), .req(req), .din(din), .pat(pat), .pat_load(pat_load),
    .gnt(s_gnt), .busy(s_busy), .match(s_match), .match_id(s_mid),
    .match_cnt0(s_c0), .match_cnt1(s_c1), .done(s_done)
  );

  typedef struct {
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic       match;
    logic       mid;
    int         c0;
    int         c1;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passed = 0;

  // reference model state
  int         ms;     // 0 idle, 1 run, 2 done
  bit         mw, mlast, mmatch, mmid;
  int         mbits, mc0, mc1;
  logic [2:0] mhist;
  logic [3:0] mpat;

  // observation bookkeeping
  int         cyc = 0;
  int         nmatch = 0;
  int         ndone = 0;
  logic [1:0] prev_gnt = 2'b00;
  logic [1:0] gl[$];
  int         gcyc[$];
  int         dcyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int clip3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic model_reset();
    ms = 0; mw = 0; mlast = 1; mbits = 0; mhist = '0; mpat = 4'b1001;
    mmatch = 0; mmid = 0; mc0 = 0; mc1 = 0;
  endtask

  task automatic model_edge();
    bit         b;
    logic [3:0] cand;
    case (ms)
      0: begin
        mmatch = 0;
        if (pat_load) mpat = pat;
        if (req != 2'b00) begin
          if (req == 2'b11) mw = !mlast;
          else              mw = req[1];
          mlast = mw; mbits = 0; mhist = '0; ms = 1;
        end
      end
      1: begin
        if (!req[mw]) begin
          mmatch = 0; ms = 2;
        end else begin
          b = din[mw];
          cand = {mhist, b};
          mmatch = (cand == mpat) && (mbits >= 3);
          if (mmatch) begin
            mmid = mw;
            if (mw) mc1++; else mc0++;
          end
          mhist = {mhist[1:0], b};
          mbits++;
          if (mbits == 8) ms = 2;
        end
      end
      default: begin
        mmatch = 0; ms = 0;
      end
    endcase
  endtask

  // one clock: predict, push, advance, pop, compare
  task automatic tick();
    exp_t e;
    model_edge();
    e.gnt   = (ms == 1) ? (mw ? 2'b10 : 2'b01) : 2'b00;
    e.busy  = (ms == 1);
    e.done  = (ms == 2);
    e.match = mmatch;
    e.mid   = mmid;
    e.c0    = mc0;
    e.c1    = mc1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    chk("gnt", gnt, e.gnt);
    chk("busy", busy, e.busy);
    chk("done", done, e.done);
    chk("match", match, e.match);
    if (e.match) chk("match_id", match_id, e.mid);
    chk("cnt0", c0, e.c0);
    chk("cnt1", c1, e.c1);
    chk("sat_gnt", s_gnt, e.gnt);
    chk("sat_busy", s_busy, e.busy);
    chk("sat_done", s_done, e.done);
    chk("sat_match", s_match, e.match);
    if (e.match) chk("sat_match_id", s_mid, e.mid);
    chk("sat_cnt0", s_c0, clip3(e.c0));
    chk("sat_cnt1", s_c1, clip3(e.c1));
    if (match) nmatch++;
    if (done) begin ndone++; dcyc.push_back(cyc); end
    if (gnt != 2'b00 && prev_gnt == 2'b00) begin
      gl.push_back(gnt);
      gcyc.push_back(cyc);
    end
    prev_gnt = gnt;
  endtask

  initial begin
    logic [7:0] bits;
    logic [4:0] ab;
    int         base1;

    rst = 1'b0; req = 2'b00; din = 2'b00; pat = 4'b0000; pat_load = 1'b0;
    model_reset();

    // reset state
    #12;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_match", match, 0);
    chk("rst_match_id", match_id, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt0", c0, 0);
    chk("rst_cnt1", c1, 0);
    rst = 1'b1;

    // default pattern 1001 on requester 0
    req = 2'b01;
    tick();
    nmatch = 0;
    bits = 8'b10010010;
    for (int i = 7; i >= 0; i--) begin
      din = {1'b0, bits[i]};
      tick();
    end
    chk("t1_done_after_bit8", done, 1);
    chk("t1_match_pulses", nmatch, 2);
    chk("t1_cnt0", c0, 2);
    req = 2'b00;
    tick();
    tick();

    // async reset mid-frame, between clock edges
    req = 2'b01;
    din = 2'b01;
    tick();
    tick();
    tick();
    tick();
    #3 rst = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_match", match, 0);
    chk("arst_match_id", match_id, 0);
    chk("arst_done", done, 0);
    chk("arst_cnt0", c0, 0);
    chk("arst_cnt1", c1, 0);
    model_reset();
    prev_gnt = 2'b00;
    #2 rst = 1'b1;

    // round robin, both requesting for three frames
    req = 2'b11;
    gl.delete(); gcyc.delete(); dcyc.delete();
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      din = 2'($urandom_range(0, 3));
      tick();
    end
    req = 2'b00;
    chk("rr_grants", gl.size(), 3);
    chk("rr_done_count", ndone, 3);
    if (gl.size() == 3 && dcyc.size() == 3) begin
      chk("rr_grant0", gl[0], 2'b01);
      chk("rr_grant1", gl[1], 2'b10);
      chk("rr_grant2", gl[2], 2'b01);
      chk("rr_gap", gcyc[1] - dcyc[0], 2);
    end
    tick();

    // programmable pattern 1111 on requester 1, mid-frame load ignored
    pat = 4'b1111; pat_load = 1'b1;
    tick();
    pat_load = 1'b0;
    base1 = int'(c1);
    req = 2'b10; din = 2'b11;
    tick();
    nmatch = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin pat = 4'b0000; pat_load = 1'b1; end
      tick();
    end
    pat_load = 1'b0;
    chk("t3_match_pulses", nmatch, 5);
    chk("t3_cnt1_delta", int'(c1) - base1, 5);
    req = 2'b00;
    tick();
    tick();

    // saturation of 2-bit counters on requester 0
    req = 2'b01; din = 2'b11;
    nmatch = 0;
    for (int i = 0; i < 20; i++) tick();
    req = 2'b00;
    chk("sat_match_pulses", nmatch, 10);
    chk("sat_cnt0_stuck", s_c0, 3);
    tick();

    // abort after 5 bits, history must not carry into the next frame
    pat = 4'b1001; pat_load = 1'b1;
    tick();
    pat_load = 1'b0;
    req = 2'b01;
    tick();
    ab = 5'b11100;
    for (int i = 4; i >= 0; i--) begin
      din = {1'b0, ab[i]};
      tick();
    end
    req = 2'b00;
    nmatch = 0;
    tick();
    chk("t4_abort_done", done, 1);
    tick();
    req = 2'b01;
    tick();
    bits = 8'b10110110;
    for (int i = 7; i >= 0; i--) begin
      din = {1'b0, bits[i]};
      tick();
    end
    chk("t4_no_cross_match", nmatch, 0);
    req = 2'b00;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
